nnet_frame_scheduler: RTL

NNET_FRAME_SCHEDULER -- requirements
Module: nnet_frame_scheduler

---
 rtl/nnet_frame_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/nnet_frame_scheduler.sv
// Frame admission scheduler around an HLS core: zero-latency pass-through on input and output paths, ready/valid passed straight through.
// Admission is capped at MAX_INFLIGHT open frames; the output-stall watchdog exists only with NNET_SCHED_WATCHDOG_EN defined.
module nnet_frame_scheduler #(
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned WDOG_CYCLES  = 65535
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        enable,
    input  logic [15:0] pkt_size_in,
    input  logic [15:0] pkt_size_out,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_core_tdata,
    output logic        m_core_tvalid,
    input  logic        m_core_tready,
    input  logic [31:0] s_core_tdata,
    input  logic        s_core_tvalid,
    output logic        s_core_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [3:0]  inflight,
    output logic        busy,
    output logic        err_short,
    output logic        err_orphan,
    output logic        wdog_flag
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FEED = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [4:0] MAX_W = 5'(MAX_INFLIGHT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_in_cnt;
    logic [15:0] r_out_cnt;
    logic [15:0] r_sz_in;
    logic [15:0] r_sz_out;
    logic [3:0]  r_inflight;
    logic [3:0]  w_inflight_nxt;
    logic        r_err_short;
    logic        r_err_orphan;
    logic        w_feed;
    logic        w_in_hs;
    logic        w_in_last_beat;
    logic        w_in_end;
    logic        w_out_act;
    logic        w_out_hs;
    logic        w_out_last_beat;
    logic        w_out_end;
    logic        w_slot_free;
    logic        w_slot_after;
    logic        w_can_start;
    logic        w_wdog_fire;

    assign w_in_hs         = w_feed && s_tvalid && m_core_tready;
    assign w_in_last_beat  = (r_in_cnt == r_sz_in - 16'd1);
    assign w_in_end        = w_in_hs && w_in_last_beat;
    assign w_out_act       = ap_rst_n && (r_inflight != 4'd0);
    assign w_out_hs        = w_out_act && s_core_tvalid && m_tready;
    assign w_out_last_beat = (r_out_cnt == r_sz_out - 16'd1);
    assign w_out_end       = w_out_hs && w_out_last_beat;
    assign w_slot_free     = ({1'b0, r_inflight} < MAX_W);
    assign w_slot_after    = (({1'b0, r_inflight} + 5'd1) < MAX_W);
    assign w_can_start     = enable && (pkt_size_in != 16'd0) && (pkt_size_out != 16'd0) && w_slot_free;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // enable is only consulted at frame boundaries, so a started frame always finishes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_can_start) w_state_nxt = S_FEED;
            S_FEED: begin
                if (w_in_end) begin
                    if (!enable)           w_state_nxt = S_IDLE;
                    else if (!w_slot_after) w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable)          w_state_nxt = S_IDLE;
                else if (w_slot_free) w_state_nxt = S_FEED;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_feed        = ap_rst_n && (r_state == S_FEED);
        s_tready      = w_feed && m_core_tready;
        m_core_tvalid = w_feed && s_tvalid;
    end

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_in_end && !w_out_end)      w_inflight_nxt = r_inflight + 4'd1;
        else if (!w_in_end && w_out_end) w_inflight_nxt = r_inflight - 4'd1;
        if (w_wdog_fire)                 w_inflight_nxt = 4'd0;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_in_cnt     <= 16'd0;
            r_out_cnt    <= 16'd0;
            r_sz_in      <= 16'd0;
            r_sz_out     <= 16'd0;
            r_inflight   <= 4'd0;
            r_err_short  <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if ((r_state == S_IDLE) && w_can_start) r_sz_in <= pkt_size_in;
            // output size may only change between output frames with nothing pending
            if ((r_inflight == 4'd0) && (r_out_cnt == 16'd0)) r_sz_out <= pkt_size_out;
            if (w_in_hs) r_in_cnt <= w_in_last_beat ? 16'd0 : r_in_cnt + 16'd1;
            if (w_wdog_fire)   r_out_cnt <= 16'd0;
            else if (w_out_hs) r_out_cnt <= w_out_last_beat ? 16'd0 : r_out_cnt + 16'd1;
            if (w_in_hs && (s_tlast != w_in_last_beat)) r_err_short <= 1'b1;
            if (!w_out_act && s_core_tvalid) r_err_orphan <= 1'b1;
        end
    end

`ifdef NNET_SCHED_WATCHDOG_EN
    logic [15:0] r_wdog_cnt;
    logic        r_wdog_flag;

    assign w_wdog_fire = w_out_act && !w_out_hs && (r_wdog_cnt == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_wdog_cnt  <= 16'd0;
            r_wdog_flag <= 1'b0;
        end else begin
            if (!w_out_act || w_out_hs || w_wdog_fire) r_wdog_cnt <= 16'd0;
            else                                       r_wdog_cnt <= r_wdog_cnt + 16'd1;
            if (w_wdog_fire) r_wdog_flag <= 1'b1;
        end
    end

    assign wdog_flag = r_wdog_flag;
`else
    assign w_wdog_fire = 1'b0;
    assign wdog_flag   = 1'b0;
`endif

    assign m_core_tdata  = s_tdata;
    assign m_tdata       = s_core_tdata;
    assign m_tvalid      = w_out_act && s_core_tvalid;
    assign s_core_tready = w_out_act ? m_tready : 1'b1;
    assign m_tlast       = w_out_act && w_out_last_beat;
    assign inflight      = ap_rst_n ? r_inflight : 4'd0;
    assign busy          = ap_rst_n && ((r_state != S_IDLE) || (r_inflight != 4'd0));
    assign err_short     = r_err_short;
    assign err_orphan    = r_err_orphan;
endmodule
